// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first two's-complement subtractor D = A - B with borrow-out.
// Optional signed overflow flag V is built only when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             V
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q, d_q, r_sr_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q, busy_q, done_q;
  logic             d_bit, b_bit, last;
  always_comb begin
    d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    b_bit  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    r_sr_d = {d_bit, r_sr_q[WIDTH-1:1]};
    last   = cnt_q == CW'(WIDTH - 1);
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            a_sr_q   <= A;
            b_sr_q   <= B;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          r_sr_q   <= r_sr_d;
          borrow_q <= b_bit;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            d_q     <= r_sr_d;
            bout_q  <= b_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic msb_a_q, msb_b_q, v_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      v_q     <= 1'b0;
    end else if (state_q == IDLE && START) begin
      msb_a_q <= A[WIDTH-1];
      msb_b_q <= B[WIDTH-1];
    end else if (state_q == SHIFT && last) begin
      // d_bit here is the result MSB, produced on the final shift
      v_q <= (msb_a_q != msb_b_q) && (d_bit != msb_a_q);
    end
  end
  assign V = v_q;
`else
  assign V = 1'b0;
`endif
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign D    = d_q;
  assign BOUT = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, corner sequences and random ops against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;
`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic         CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [W-1:0] A = '0, B = '0, D;
  logic         BUSY, DONE, BOUT, V;
  int           total = 0, bad = 0;
  logic [W-1:0] prev_d = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .D(D), .BOUT(BOUT), .V(V)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a, b, d;
    logic         bo, v;
  } vec_t;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, b, output logic [W-1:0] d,
                                output logic bo, output logic v);
    int r;
    d  = W'(int'(a) - int'(b));
    bo = a < b;
    r  = int'($signed(a)) - int'($signed(b));
    v  = OVF && (r > 127 || r < -128);
  endfunction

  task automatic op(input logic [W-1:0] a, b, output logic [W-1:0] d,
                    output logic bo, output logic vv);
    int n, bc, both;
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom);
    chk("d_hold_on_start", D, prev_d);
    n = 0; bc = 0; both = 0;
    while (!DONE && n < 30) begin
      if (BUSY) bc++;
      @(negedge CLK);
      n++;
    end
    if (BUSY && DONE) both++;
    chk("done_latency", n, W);
    chk("busy_len", bc, W);
    chk("busy_done_excl", both, 0);
    d = D; bo = BOUT; vv = V;
    prev_d = D;
    @(negedge CLK);
    chk("done_one_cycle", DONE, 0);
    chk("d_hold_after", D, prev_d);
  endtask

  initial begin
    vec_t         tbl[5];
    logic [W-1:0] gd, ed;
    logic         gb, gv, eb, ev, pb;
    int           rises[$];
    int           dn, n;
    logic [W-1:0] dd[2];
    logic         db[2];
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, OVF};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, OVF};

    repeat (2) @(negedge CLK);
    chk("reset_outputs", {BUSY, DONE, D, BOUT, V}, 0);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, gd, gb, gv);
      chk($sformatf("tbl%0d_d", i), gd, tbl[i].d);
      chk($sformatf("tbl%0d_bout", i), gb, tbl[i].bo);
      chk($sformatf("tbl%0d_v", i), gv, tbl[i].v);
    end

    // START held high: 0x00-0x00 then 0xFF-0xFF back to back
    @(negedge CLK);
    A = 8'h00; B = 8'h00; START = 1'b1;
    pb = BUSY; dn = 0; n = 0;
    while (dn < 2 && n < 40) begin
      @(negedge CLK);
      n++;
      if (BUSY && !pb) begin
        rises.push_back(n);
        A = 8'hFF; B = 8'hFF;
      end
      pb = BUSY;
      if (DONE) begin
        dd[dn] = D; db[dn] = BOUT;
        dn++;
      end
    end
    START = 1'b0;
    chk("b2b_dones", dn, 2);
    chk("b2b_accepts", rises.size(), 2);
    if (rises.size() == 2) chk("b2b_period", rises[1] - rises[0], W + 2);
    chk("b2b_d0", {dd[0], db[0]}, 0);
    chk("b2b_d1", {dd[1], db[1]}, 0);
    prev_d = D;
    @(negedge CLK);

    // START mid-SHIFT is ignored
    @(negedge CLK);
    A = 8'h10; B = 8'h01; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    A = 8'hAA; B = 8'h55; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    dn = 0; rises.delete(); pb = BUSY;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin
        dn++; gd = D; gb = BOUT;
      end
      if (BUSY && !pb) rises.push_back(i);
      pb = BUSY;
      @(negedge CLK);
    end
    chk("mid_dones", dn, 1);
    chk("mid_no_restart", rises.size(), 0);
    chk("mid_d", gd, 8'h0F);
    chk("mid_bout", gb, 0);
    prev_d = D;

    // reset at bit 4 aborts the operation
    @(negedge CLK);
    A = 8'h37; B = 8'h12; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_mid_outputs", {BUSY, DONE, D, BOUT, V}, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE || BUSY) dn++;
      @(negedge CLK);
    end
    chk("rst_mid_idle", dn, 0);
    prev_d = '0;
    op(8'h37, 8'h12, gd, gb, gv);
    chk("rst_after_d", gd, 8'h25);
    chk("rst_after_bout", gb, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      model(ra, rb, ed, eb, ev);
      op(ra, rb, gd, gb, gv);
      chk($sformatf("rnd%0d_%0h_%0h", i, ra, rb), {gd, gb, gv}, {ed, eb, ev});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
